rv_target_bfm: RTL and testbench

RV_TARGET_BFM -- requirements
Module: rv_target_bfm

---
 rtl/rv_bfm_pkg.sv | 13 +
 rtl/rv_target_fifo.sv | 63 ++++++
 rtl/rv_target_bfm.sv | 105 ++++++++++
 tb/tb_rv_target_bfm.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_bfm_pkg.sv
// Shared types and widths for the ready/valid target bus-functional model.
// The FSM enum and counter widths live here so the top and the bench agree.
package rv_bfm_pkg;

    localparam int STALL_W = 8;
    localparam int BEAT_W  = 32;

    typedef enum logic {
        READY = 1'b0,
        STALL = 1'b1
    } state_e;

endpackage

// File: rtl/rv_target_fifo.sv
// Receive FIFO for the target BFM: power-of-two depth, head visible combinationally,
// push accepted while full only when a pop frees the head slot on the same edge.
module rv_target_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wr_dat_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rd_dat_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o   = (count_q == DEPTH_C);
    assign empty_o  = (count_q == '0);
    assign do_pop   = pop_i & ~empty_o;
    assign do_push  = push_i & (~full_o | do_pop);
    assign rd_dat_o = mem_q[rd_ptr_q];
    assign count_o  = count_q;

    // NOTE: storage is deliberately not reset; occupancy and pointers define validity.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rv_target_bfm.sv
// Ready/valid target BFM: registered t_ready with programmable post-beat stall,
// received beats queued in rv_target_fifo for the testbench side.
module rv_target_bfm
    import rv_bfm_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       t_dat,
    input  logic                   t_valid,
    output logic                   t_ready,
    input  logic                   cfg_en,
    input  logic [STALL_W-1:0]     cfg_stall,
    output logic [WIDTH-1:0]       rx_dat,
    output logic                   rx_valid,
    input  logic                   rx_pop,
    output logic [$clog2(DEPTH):0] rx_count,
    output logic [BEAT_W-1:0]      beat_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_e             state_q;
    logic [STALL_W-1:0] stall_cnt_q;
    logic [BEAT_W-1:0]  beat_cnt_q;
    logic               t_ready_q;

    logic               accept;
    logic               pop_ok;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   count_d;
    logic               stall_enter;
    logic               stall_exit;
    logic               ready_d;

    assign accept = t_valid & t_ready_q & ~fifo_full;
    assign pop_ok = rx_pop & ~fifo_empty;

    // t_ready is registered, so it is computed from the occupancy and state after this edge.
    assign count_d     = fifo_count + CNT_W'(accept) - CNT_W'(pop_ok);
    assign stall_enter = (state_q == READY) && accept && (cfg_stall != '0);
    assign stall_exit  = (state_q == STALL) && (stall_cnt_q == STALL_W'(1));
    assign ready_d     = (state_q == READY) ? ~stall_enter : stall_exit;

    rv_target_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_i   (accept),
        .wr_dat_i (t_dat),
        .pop_i    (pop_ok),
        .rd_dat_o (rx_dat),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count)
    );

    // NOTE: sequential state uses <= so every register sees pre-edge values of its peers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= READY;
            stall_cnt_q <= '0;
            beat_cnt_q  <= '0;
            t_ready_q   <= 1'b0;
        end else begin
            t_ready_q <= cfg_en & ready_d & (count_d < DEPTH_C);
            if (accept) begin
                beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
            end
            case (state_q)
                READY: begin
                    if (stall_enter) begin
                        state_q     <= STALL;
                        stall_cnt_q <= cfg_stall;
                    end
                end
                STALL: begin
                    if (stall_exit) begin
                        state_q     <= READY;
                        stall_cnt_q <= '0;
                    end else begin
                        stall_cnt_q <= stall_cnt_q - STALL_W'(1);
                    end
                end
                default: begin
                    state_q     <= READY;
                    stall_cnt_q <= '0;
                end
            endcase
        end
    end

    assign t_ready    = t_ready_q;
    assign rx_valid   = ~fifo_empty;
    assign rx_count   = fifo_count;
    assign beat_count = beat_cnt_q;

endmodule

// File: tb/tb_rv_target_bfm.sv
// Directed bench for rv_target_bfm: reset, streaming, stall, full, reset mid-stall,
// cfg_en gating, plus a standalone FIFO push/pop-at-full check.
module tb_rv_target_bfm;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clock = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] t_dat;
    logic             t_valid;
    logic             t_ready;
    logic             cfg_en;
    logic [7:0]       cfg_stall;
    logic [WIDTH-1:0] rx_dat;
    logic             rx_valid;
    logic             rx_pop;
    logic [CNT_W-1:0] rx_count;
    logic [31:0]      beat_count;

    logic             f_push;
    logic             f_pop;
    logic [7:0]       f_wdat;
    logic [7:0]       f_rdat;
    logic             f_full;
    logic             f_empty;
    logic [2:0]       f_count;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    rv_target_bfm #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .t_dat      (t_dat),
        .t_valid    (t_valid),
        .t_ready    (t_ready),
        .cfg_en     (cfg_en),
        .cfg_stall  (cfg_stall),
        .rx_dat     (rx_dat),
        .rx_valid   (rx_valid),
        .rx_pop     (rx_pop),
        .rx_count   (rx_count),
        .beat_count (beat_count)
    );

    rv_target_fifo #(
        .WIDTH (8),
        .DEPTH (4)
    ) fifo_u (
        .clock    (clock),
        .reset    (reset),
        .push_i   (f_push),
        .wr_dat_i (f_wdat),
        .pop_i    (f_pop),
        .rd_dat_o (f_rdat),
        .full_o   (f_full),
        .empty_o  (f_empty),
        .count_o  (f_count)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] drain_exp [3];
        drain_exp = '{32'h99, 32'h30, 32'h31};

        reset = 1'b1; cfg_en = 1'b1; cfg_stall = 8'd0;
        t_valid = 1'b0; t_dat = '0; rx_pop = 1'b0;
        f_push = 1'b0; f_pop = 1'b0; f_wdat = 8'h00;
        tick();
        tick();
        check("reset_t_ready",  64'(t_ready),    64'(0));
        check("reset_rx_valid", 64'(rx_valid),   64'(0));
        check("reset_rx_count", 64'(rx_count),   64'(0));
        check("reset_beats",    64'(beat_count), 64'(0));
        reset = 1'b0;
        check("rel_ready_lo", 64'(t_ready), 64'(0));
        tick();
        check("rel_ready_hi", 64'(t_ready), 64'(1));

        // Back-to-back streaming with the sink popping every cycle
        rx_pop = 1'b1; t_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            t_dat = 32'(i);
            check("b2b_ready", 64'(t_ready), 64'(1));
            tick();
            check("b2b_dat",   64'(rx_dat),   64'(i));
            check("b2b_count", 64'(rx_count), 64'(1));
        end
        t_valid = 1'b0;
        check("b2b_beats", 64'(beat_count), 64'(8));
        tick();
        check("b2b_drain", 64'(rx_valid), 64'(0));
        rx_pop = 1'b0;

        // Stall of 3 cycles; cfg_stall change and offered data during stall are ignored
        cfg_stall = 8'd3; t_valid = 1'b1; t_dat = 32'hA5A5A5A5;
        check("stall_pre_ready", 64'(t_ready), 64'(1));
        tick();
        check("stall_dat",   64'(rx_dat),     64'(32'hA5A5A5A5));
        check("stall_beats", 64'(beat_count), 64'(9));
        t_dat = 32'hDEADBEEF; cfg_stall = 8'd7;
        for (int k = 0; k < 3; k++) begin
            check("stall_low", 64'(t_ready), 64'(0));
            tick();
        end
        check("stall_release", 64'(t_ready), 64'(1));
        t_valid = 1'b0;
        check("stall_ign_count", 64'(rx_count),   64'(1));
        check("stall_ign_beats", 64'(beat_count), 64'(9));
        cfg_stall = 8'd0; rx_pop = 1'b1;
        tick();
        check("stall_pop", 64'(rx_valid), 64'(0));
        rx_pop = 1'b0;

        // Fill to DEPTH with no pops, then hold off extra beats
        t_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            t_dat = 32'(8'h11 + i);
            check("full_fill_ready", 64'(t_ready), 64'(1));
            tick();
        end
        check("full_ready_lo", 64'(t_ready),  64'(0));
        check("full_count",    64'(rx_count), 64'(4));
        t_dat = 32'h15;
        tick();
        tick();
        check("full_hold_count", 64'(rx_count),   64'(4));
        check("full_hold_beats", 64'(beat_count), 64'(13));
        check("full_hold_ready", 64'(t_ready),    64'(0));
        check("full_head", 64'(rx_dat), 64'(32'h11));
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
        check("full_reopen",       64'(t_ready),  64'(1));
        check("full_reopen_count", 64'(rx_count), 64'(3));
        tick();
        check("full_fifth_count", 64'(rx_count),   64'(4));
        check("full_fifth_beats", 64'(beat_count), 64'(14));
        check("full_fifth_ready", 64'(t_ready),    64'(0));

        // Continuous push+pop: occupancy constant, order preserved
        rx_pop = 1'b1; t_dat = 32'h16;
        check("pp_head0", 64'(rx_dat), 64'(32'h12));
        tick();
        check("pp_head", 64'(rx_dat), 64'(32'h13));
        for (int j = 1; j <= 4; j++) begin
            tick();
            check("pp_head",  64'(rx_dat),   64'(8'h13 + j));
            check("pp_count", 64'(rx_count), 64'(3));
            t_dat = 32'(8'h16 + j);
        end
        t_valid = 1'b0;
        check("pp_beats", 64'(beat_count), 64'(18));

        // Reset with 3 entries while stalling
        tick();
        rx_pop = 1'b0;
        check("rst_pre_head", 64'(rx_dat), 64'(32'h18));
        t_valid = 1'b1; t_dat = 32'h20; cfg_stall = 8'd5;
        check("rst_pre_ready", 64'(t_ready), 64'(1));
        tick();
        t_valid = 1'b0;
        check("rst_pre_count", 64'(rx_count),   64'(3));
        check("rst_pre_stall", 64'(t_ready),    64'(0));
        check("rst_pre_beats", 64'(beat_count), 64'(19));
        tick();
        reset = 1'b1; t_valid = 1'b1; t_dat = 32'h99;
        tick();
        check("rst_rx_valid", 64'(rx_valid),   64'(0));
        check("rst_rx_count", 64'(rx_count),   64'(0));
        check("rst_beats",    64'(beat_count), 64'(0));
        check("rst_ready",    64'(t_ready),    64'(0));
        reset = 1'b0; cfg_stall = 8'd0;
        check("rst_rel_lo", 64'(t_ready), 64'(0));
        tick();
        check("rst_rel_hi",    64'(t_ready),  64'(1));
        check("rst_rel_count", 64'(rx_count), 64'(0));
        tick();
        check("rst_new_dat",   64'(rx_dat),     64'(32'h99));
        check("rst_new_count", 64'(rx_count),   64'(1));
        check("rst_new_beats", 64'(beat_count), 64'(1));

        // cfg_en drop: beat on the falling edge is kept, then no accepts
        t_dat = 32'h30; cfg_en = 1'b0;
        tick();
        check("en_ready_lo", 64'(t_ready),    64'(0));
        check("en_count",    64'(rx_count),   64'(2));
        check("en_beats",    64'(beat_count), 64'(2));
        t_dat = 32'h31;
        tick();
        tick();
        check("en_hold_count", 64'(rx_count),   64'(2));
        check("en_hold_beats", 64'(beat_count), 64'(2));
        check("en_hold_ready", 64'(t_ready),    64'(0));
        cfg_en = 1'b1;
        tick();
        check("en_back_ready", 64'(t_ready),  64'(1));
        check("en_back_count", 64'(rx_count), 64'(2));
        tick();
        t_valid = 1'b0;
        check("en_accept_count", 64'(rx_count),   64'(3));
        check("en_accept_beats", 64'(beat_count), 64'(3));
        rx_pop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("en_drain_dat", 64'(rx_dat), 64'(drain_exp[i]));
            tick();
        end
        check("en_drain_empty", 64'(rx_valid), 64'(0));
        tick();
        check("pop_empty_count", 64'(rx_count), 64'(0));
        rx_pop = 1'b0;

        // Standalone FIFO: simultaneous push and pop while full
        f_push = 1'b1;
        for (int i = 0; i < 4; i++) begin
            f_wdat = 8'(i + 1);
            tick();
        end
        check("fifo_full",  64'(f_full),  64'(1));
        check("fifo_count", 64'(f_count), 64'(4));
        f_wdat = 8'h05; f_pop = 1'b1;
        check("fifo_head", 64'(f_rdat), 64'(1));
        tick();
        check("fifo_pp_count", 64'(f_count), 64'(4));
        check("fifo_pp_head",  64'(f_rdat),  64'(2));
        f_wdat = 8'h06;
        tick();
        check("fifo_pp_count", 64'(f_count), 64'(4));
        f_push = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("fifo_order", 64'(f_rdat), 64'(3 + i));
            tick();
        end
        check("fifo_empty", 64'(f_empty), 64'(1));
        f_pop = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
